execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined RV64 core. It sits between decode, which supplies operands already selected per opcode (srca/srcb), and the memory stage. It consumes each decoded instruction over a valid/ready handshake, computes the ALU result and resolves BEQ/JAL/JALR. It registers the outcome into the EX/MEM pipeline register and raises a one-cycle fetch redirect for taken control transfers.

## Interface
Parameters:
- XLEN, 64, datapath width; must equal the width of word_t.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  kill the held result and any in-flight multiply
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  execute accepts this cycle
- in_pc  in  64 (u64)  instruction PC
- in_op  in  decode_op_t  decoded operation
- in_srca, in_srcb  in  word_t  operands as selected by decode
- in_rd1, in_rd2  in  word_t  raw rs1/rs2 register values
- in_imm  in  word_t  sign-extended immediate
- in_dst  in  5  destination register index
- out_valid  out  1  EX/MEM register holds a result
- out_ready  in  1  memory stage accepts
- out_pc  out  64  PC of the held instruction
- out_op  out  decode_op_t  operation of the held instruction
- out_result  out  word_t  ALU result or memory address
- out_store_data  out  word_t  in_rd2 captured for SD
- out_dst  out  5  destination register index
- redirect_valid  out  1  one-cycle pulse: fetch must restart
- redirect_pc  out  64  restart target

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !busy && (!out_valid || out_ready). This is a single-entry register with no skid buffer.
- Results:
  - ADD, ADDI, LD, SD, LUI, AUIPC, JAL, JALR: srca + srcb, mod 2^64.
  - SUB: srca − srcb.
  - AND/ANDI, OR/ORI, XOR/XORI: bitwise.
  - BEQ: result 0.
- Control transfers:
  - BEQ is taken iff in_rd1 == in_rd2; target = in_pc + in_imm.
  - JAL target = in_pc + in_imm.
  - JALR target = (in_rd1 + in_imm) & ~64'h1.
- Unknown or default op: result 0, no redirect, passed through as a bubble-free NOP.
- redirect_valid and redirect_pc are registered. They pulse for exactly one cycle, in the cycle after the transfer in of a taken BEQ/JAL/JALR. They never repeat while the result stalls on out_ready.
- flush:
  - Clears out_valid at the next edge and aborts a multiply (busy→0).
  - Suppresses any redirect for an instruction accepted in the same cycle.
  - In that cycle in_ready is forced to 1 and the input is discarded.
- If flush and out_ready are both high, flush wins and the result is dropped, not delivered.

## Timing
- Reset values: out_valid=0, redirect_valid=0, busy=0. All data outputs are 0, with redirect_pc=0 and out_op=the enum's first value.
- Single-cycle ops: accepted at edge N, visible on out_* at edge N+1.
- Back-to-back throughput is 1/cycle while out_ready=1.
- Stall: while out_valid && !out_ready, every out_* output holds stable and in_ready=0.
- Reset deassertion mid-operation: state restarts from the reset values. No partial multiply survives.

## Configuration
- MUL_EN defined:
  - decode_op_t includes MUL, computed by an iterative shift-add multiplier producing the low 64 bits of srca*srcb.
  - State machine IDLE → MUL_BUSY (64 iterations) → IDLE.
  - busy=1 during MUL_BUSY; out_valid rises at the edge ending iteration 64, so latency is 65 cycles from acceptance.
  - flush in MUL_BUSY returns the machine to IDLE with no output.
- MUL_EN undefined: no MUL op, no multiplier logic, busy tied to 0.

## Structure
- pipes package:
  - decode_op_t, with MUL guarded by MUL_EN.
  - ex_mem_t, a packed struct holding pc, op, result, store_data and dst.
  - the redirect struct.
- common package: word_t, u64, XLEN.
- Sub-module `iter_mul`:
  - handshake: start, done, abort;
  - 7-bit iteration counter;
  - instantiated only under MUL_EN.

## Test plan
- Reset low with in_valid=1 → out_valid=0, redirect_valid=0, in_ready=1 after release.
- ADDI srca=5, srcb=−3 accepted at edge 1 → out_result=2 at edge 2. Then SUB 0−1 → 64'hFFFF_FFFF_FFFF_FFFF.
- BEQ in_rd1=in_rd2=7, pc=0x100, imm=0x20 → redirect_valid pulse 1 cycle, redirect_pc=0x120. Repeat with rd2=8 → no redirect, result 0.
- JALR rd1=0x203, imm=0, srca=0x400, srcb=4 → out_result=0x404, redirect_pc=0x202.
- out_ready=0 for 3 cycles with a held XOR result → outputs stable, in_ready=0, single redirect only. Assert flush → out_valid=0 next cycle.
- MUL_EN: MUL 0x1234×0x10 → out_result=0x12340 exactly 65 cycles after acceptance. A flush at iteration 10 → no output, in_ready=1 next cycle.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared types for the execute stage.
//   common : datapath word types and width.
//   pipes  : decoded operation, EX/MEM register layout, fetch redirect.
// Optional feature macro: MUL_EN (adds the MUL operation to decode_op_t).
package common;
    localparam int XLEN = 64;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [63:0]     u64;
endpackage

package pipes;
    import common::word_t;
    import common::u64;

    // OP_NOP stays first so a cleared register reads back as a no-op.
    typedef enum logic [4:0] {
        OP_NOP,
        OP_ADD,
        OP_ADDI,
        OP_LD,
        OP_SD,
        OP_LUI,
        OP_AUIPC,
        OP_JAL,
        OP_JALR,
        OP_SUB,
        OP_AND,
        OP_ANDI,
        OP_OR,
        OP_ORI,
        OP_XOR,
        OP_XORI,
`ifdef MUL_EN
        OP_MUL,
`endif
        OP_BEQ
    } decode_op_t;

    typedef struct packed {
        u64         pc;
        decode_op_t op;
        word_t      result;
        word_t      store_data;
        logic [4:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic valid;
        u64   pc;
    } redirect_t;
endpackage

// File: rtl/execute_stage_mul.sv
// Iterative shift-add multiplier (low 64 bits of a*b), one partial product
// per cycle for 64 cycles. Only present when MUL_EN is defined.
`ifdef MUL_EN
module iter_mul
    import common::word_t;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  start,
    input  logic  abort,
    input  word_t a,
    input  word_t b,
    output logic  busy,
    output logic  done,
    output word_t product
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    logic [0:0] state;
    logic [6:0] count;
    word_t      mcand;
    word_t      mplier;
    word_t      acc;

    assign busy    = (state == MUL_BUSY);
    assign done    = busy && (count == 7'd64);
    assign product = acc;

    // Sequencer: load operands on start, add/shift 64 times, hold done for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (abort) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= MUL_BUSY;
                        count  <= '0;
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                    end
                end
                MUL_BUSY: begin
                    if (count == 7'd64) begin
                        state <= IDLE;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: ALU, BEQ/JAL/JALR resolution, single-entry EX/MEM register
// and a registered one-cycle fetch redirect.
// Optional feature macro: MUL_EN (iterative 64-cycle multiplier, iter_mul).
module execute_stage
    import common::word_t;
    import common::u64;
    import pipes::*;
#(
    parameter int XLEN = common::XLEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  u64         in_pc,
    input  decode_op_t in_op,
    input  word_t      in_srca,
    input  word_t      in_srcb,
    input  word_t      in_rd1,
    input  word_t      in_rd2,
    input  word_t      in_imm,
    input  logic [4:0] in_dst,
    output logic       out_valid,
    input  logic       out_ready,
    output u64         out_pc,
    output decode_op_t out_op,
    output word_t      out_result,
    output word_t      out_store_data,
    output logic [4:0] out_dst,
    output logic       redirect_valid,
    output u64         redirect_pc
);
    function automatic word_t alu(input decode_op_t op, input word_t a, input word_t b);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_SD,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: alu = a + b;
            OP_SUB:                            alu = a - b;
            OP_AND, OP_ANDI:                   alu = a & b;
            OP_OR,  OP_ORI:                    alu = a | b;
            OP_XOR, OP_XORI:                   alu = a ^ b;
            default:                           alu = '0;
        endcase
    endfunction

    logic [XLEN-1:0] alu_p0;
    logic            taken_p0;
    u64              target_p0;
    logic            accept_p0;
    logic            is_mul_p0;
    logic            busy;
    ex_mem_t         ex_mem_p1;
    logic            vld_p1;
    redirect_t       redirect_p1;

    // ---- stage p0: combinational execute of the offered instruction ----
    assign alu_p0 = alu(in_op, in_srca, in_srcb);

    // Resolve taken-ness and restart target for control transfers
    always_comb begin
        taken_p0  = 1'b0;
        target_p0 = '0;
        case (in_op)
            OP_BEQ: begin
                taken_p0  = (in_rd1 == in_rd2);
                target_p0 = in_pc + in_imm;
            end
            OP_JAL: begin
                taken_p0  = 1'b1;
                target_p0 = in_pc + in_imm;
            end
            OP_JALR: begin
                taken_p0  = 1'b1;
                target_p0 = (in_rd1 + in_imm) & ~64'h1;
            end
            default: ;
        endcase
    end

    // flush forces ready so decode's offer is consumed and thrown away
    assign in_ready  = flush || (!busy && (!vld_p1 || out_ready));
    assign accept_p0 = in_valid && in_ready && !flush;

`ifdef MUL_EN
    logic       mul_start;
    logic       mul_done;
    word_t      mul_product;
    u64         mul_pc;
    decode_op_t mul_op;
    word_t      mul_sd;
    logic [4:0] mul_dst;

    assign is_mul_p0 = (in_op == OP_MUL);
    assign mul_start = accept_p0 && is_mul_p0;

    iter_mul u_iter_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush),
        .a       (in_srca),
        .b       (in_srcb),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Park the multiply's bookkeeping fields until the product is ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_pc  <= '0;
            mul_op  <= OP_NOP;
            mul_sd  <= '0;
            mul_dst <= '0;
        end else if (mul_start) begin
            mul_pc  <= in_pc;
            mul_op  <= in_op;
            mul_sd  <= in_rd2;
            mul_dst <= in_dst;
        end
    end
`else
    assign is_mul_p0 = 1'b0;
    assign busy      = 1'b0;
`endif

    // ---- stage p1: EX/MEM register ----
    // Load on accept (or multiply completion), drain on out transfer, drop on flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            ex_mem_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1    <= !is_mul_p0;
            ex_mem_p1 <= '{pc: in_pc, op: in_op, result: alu_p0,
                           store_data: in_rd2, dst: in_dst};
        end
`ifdef MUL_EN
        else if (mul_done) begin
            vld_p1    <= 1'b1;
            ex_mem_p1 <= '{pc: mul_pc, op: mul_op, result: mul_product,
                           store_data: mul_sd, dst: mul_dst};
        end
`endif
        else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    // Redirect pulses only on the accepting edge, so a stalled result never repeats it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_p1 <= '0;
        end else begin
            redirect_p1.valid <= accept_p0 && taken_p0;
            if (accept_p0 && taken_p0) redirect_p1.pc <= target_p0;
        end
    end

    assign out_valid      = vld_p1;
    assign out_pc         = ex_mem_p1.pc;
    assign out_op         = ex_mem_p1.op;
    assign out_result     = ex_mem_p1.result;
    assign out_store_data = ex_mem_p1.store_data;
    assign out_dst        = ex_mem_p1.dst;
    assign redirect_valid = redirect_p1.valid;
    assign redirect_pc    = redirect_p1.pc;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus a
// randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_execute_stage;
    import common::word_t;
    import common::u64;
    import pipes::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    u64         in_pc;
    decode_op_t in_op;
    word_t      in_srca, in_srcb, in_rd1, in_rd2, in_imm;
    logic [4:0] in_dst;
    logic       out_valid;
    logic       out_ready;
    u64         out_pc;
    decode_op_t out_op;
    word_t      out_result, out_store_data;
    logic [4:0] out_dst;
    logic       redirect_valid;
    u64         redirect_pc;

    int compared   = 0;
    int mismatched = 0;

    decode_op_t op_list [16] = '{OP_ADD, OP_ADDI, OP_LD, OP_SD, OP_LUI, OP_AUIPC,
                                 OP_JAL, OP_JALR, OP_SUB, OP_AND, OP_ANDI, OP_OR,
                                 OP_ORI, OP_XOR, OP_XORI, OP_BEQ};

    execute_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
        .in_srca(in_srca), .in_srcb(in_srcb), .in_rd1(in_rd1), .in_rd2(in_rd2),
        .in_imm(in_imm), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_result(out_result), .out_store_data(out_store_data), .out_dst(out_dst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input decode_op_t op, input u64 pc, input word_t a, input word_t b,
                         input word_t rd1, input word_t rd2, input word_t imm, input logic [4:0] dst);
        in_valid = 1'b1; in_op = op; in_pc = pc; in_srca = a; in_srcb = b;
        in_rd1 = rd1; in_rd2 = rd2; in_imm = imm; in_dst = dst;
    endtask

    // Reference: the value an op writes back, from the instruction-set rules
    function automatic word_t ref_result(input decode_op_t op, input word_t a, input word_t b);
        if (op inside {OP_ADD, OP_ADDI, OP_LD, OP_SD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) return a + b;
        if (op == OP_SUB) return a - b;
        if (op inside {OP_AND, OP_ANDI}) return a & b;
        if (op inside {OP_OR, OP_ORI}) return a | b;
        if (op inside {OP_XOR, OP_XORI}) return a ^ b;
        return 64'd0;
    endfunction

    // Reference: whether the op redirects fetch, and where to
    task automatic ref_ctrl(input decode_op_t op, input u64 pc, input word_t rd1, input word_t rd2,
                            input word_t imm, output bit taken, output u64 tgt);
        word_t sum;
        taken = 1'b0;
        tgt   = 64'd0;
        if (op == OP_BEQ) begin
            taken = (rd1 == rd2);
            tgt   = pc + imm;
        end else if (op == OP_JAL) begin
            taken = 1'b1;
            tgt   = pc + imm;
        end else if (op == OP_JALR) begin
            taken = 1'b1;
            sum   = rd1 + imm;
            tgt   = {sum[63:1], 1'b0};
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(OP_ADD, 64'h10, 64'd1, 64'd2, 64'd0, 64'd0, 64'd0, 5'd1);
        tick(); tick(); tick();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        compared++; if (redirect_valid !== 1'b0) begin mismatched++; $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); end
        compared++; if (out_result !== 64'd0) begin mismatched++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
        compared++; if (redirect_pc !== 64'd0) begin mismatched++; $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); end
        compared++; if (out_op !== OP_NOP) begin mismatched++; $display("FAIL reset_out_op: got %0d expected %0d", out_op, OP_NOP); end
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_addi_sub();
        drive(OP_ADDI, 64'h40, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 64'hAB, 64'd0, 5'd3);
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL addi_in_ready: got %b expected 1", in_ready); end
        tick();
        drive(OP_SUB, 64'h44, 64'd0, 64'd1, 64'd0, 64'd0, 64'd0, 5'd4);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL addi_out_valid: got %b expected 1", out_valid); end
        compared++; if (out_result !== 64'd2) begin mismatched++; $display("FAIL addi_result: got %h expected 2", out_result); end
        compared++; if (out_pc !== 64'h40) begin mismatched++; $display("FAIL addi_pc: got %h expected 40", out_pc); end
        compared++; if (out_dst !== 5'd3) begin mismatched++; $display("FAIL addi_dst: got %0d expected 3", out_dst); end
        compared++; if (out_store_data !== 64'hAB) begin mismatched++; $display("FAIL addi_store_data: got %h expected ab", out_store_data); end
        compared++; if (redirect_valid !== 1'b0) begin mismatched++; $display("FAIL addi_redirect: got %b expected 0", redirect_valid); end
        tick();
        in_valid = 1'b0;
        compared++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin mismatched++; $display("FAIL sub_result: got %h expected ffffffffffffffff", out_result); end
        compared++; if (out_op !== OP_SUB) begin mismatched++; $display("FAIL sub_op: got %0d expected %0d", out_op, OP_SUB); end
        tick();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL sub_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_beq();
        drive(OP_BEQ, 64'h100, 64'd7, 64'd7, 64'd7, 64'd7, 64'h20, 5'd0);
        tick();
        in_valid = 1'b0;
        compared++; if (redirect_valid !== 1'b1) begin mismatched++; $display("FAIL beq_taken_valid: got %b expected 1", redirect_valid); end
        compared++; if (redirect_pc !== 64'h120) begin mismatched++; $display("FAIL beq_taken_pc: got %h expected 120", redirect_pc); end
        compared++; if (out_result !== 64'd0) begin mismatched++; $display("FAIL beq_result: got %h expected 0", out_result); end
        tick();
        compared++; if (redirect_valid !== 1'b0) begin mismatched++; $display("FAIL beq_pulse_width: got %b expected 0", redirect_valid); end
        drive(OP_BEQ, 64'h100, 64'd7, 64'd8, 64'd7, 64'd8, 64'h20, 5'd0);
        tick();
        in_valid = 1'b0;
        compared++; if (redirect_valid !== 1'b0) begin mismatched++; $display("FAIL beq_not_taken: got %b expected 0", redirect_valid); end
        compared++; if (out_valid !== 1'b1 || out_result !== 64'd0) begin mismatched++; $display("FAIL beq_nt_result: got v=%b r=%h expected v=1 r=0", out_valid, out_result); end
        tick();
    endtask

    task automatic test_jalr();
        drive(OP_JALR, 64'h80, 64'h400, 64'd4, 64'h203, 64'd0, 64'd0, 5'd1);
        tick();
        in_valid = 1'b0;
        compared++; if (out_result !== 64'h404) begin mismatched++; $display("FAIL jalr_result: got %h expected 404", out_result); end
        compared++; if (redirect_valid !== 1'b1) begin mismatched++; $display("FAIL jalr_redirect_valid: got %b expected 1", redirect_valid); end
        compared++; if (redirect_pc !== 64'h202) begin mismatched++; $display("FAIL jalr_redirect_pc: got %h expected 202", redirect_pc); end
        tick();
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        drive(OP_XOR, 64'h200, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0, 64'd0, 5'd9);
        tick();
        drive(OP_ADD, 64'h204, 64'd1, 64'd1, 64'd0, 64'd0, 64'd0, 5'd2);
        for (int i = 0; i < 3; i++) begin
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
            compared++; if (out_valid !== 1'b1 || out_result !== 64'hFF00 || out_op !== OP_XOR || out_pc !== 64'h200)
                begin mismatched++; $display("FAIL stall_hold[%0d]: got v=%b r=%h pc=%h expected v=1 r=ff00 pc=200", i, out_valid, out_result, out_pc); end
            tick();
        end
        flush = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_clear: got %b expected 0", out_valid); end
        tick();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_discard: got %b expected 0", out_valid); end
        // Stalled JAL: one redirect pulse only
        drive(OP_JAL, 64'h300, 64'h300, 64'd4, 64'd0, 64'd0, 64'h40, 5'd1);
        tick();
        in_valid = 1'b0;
        compared++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h340) begin mismatched++; $display("FAIL jal_redirect: got v=%b pc=%h expected v=1 pc=340", redirect_valid, redirect_pc); end
        compared++; if (out_result !== 64'h304) begin mismatched++; $display("FAIL jal_result: got %h expected 304", out_result); end
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (redirect_valid !== 1'b0 || out_valid !== 1'b1) begin mismatched++; $display("FAIL jal_stall_single[%0d]: got rv=%b ov=%b expected rv=0 ov=1", i, redirect_valid, out_valid); end
        end
        out_ready = 1'b1;
        tick();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL jal_drain: got %b expected 0", out_valid); end
        // Flush in the accepting cycle suppresses the redirect
        drive(OP_JAL, 64'h500, 64'h500, 64'd4, 64'd0, 64'd0, 64'h80, 5'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        compared++; if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin mismatched++; $display("FAIL flush_suppress: got rv=%b ov=%b expected 0 0", redirect_valid, out_valid); end
        tick();
    endtask

    task automatic test_unknown();
        drive(decode_op_t'(5'd30), 64'h600, 64'd1, 64'd2, 64'd3, 64'd3, 64'd8, 5'd7);
        tick();
        in_valid = 1'b0;
        compared++; if (out_valid !== 1'b1 || out_result !== 64'd0 || redirect_valid !== 1'b0)
            begin mismatched++; $display("FAIL unknown_op: got v=%b r=%h rv=%b expected v=1 r=0 rv=0", out_valid, out_result, redirect_valid); end
        tick();
    endtask

    task automatic test_random();
        bit         m_valid = 1'b0;
        u64         m_pc = 0;
        decode_op_t m_op = OP_NOP;
        word_t      m_res = 0, m_sd = 0;
        logic [4:0] m_dst = 0;
        bit         m_redir = 1'b0;
        u64         m_rpc = 0;
        bit         exp_ready, acc, tk;
        u64         tg;
        int         r;
        for (int c = 0; c < 400; c++) begin
            compared++; if (out_valid !== m_valid) begin mismatched++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", c, out_valid, m_valid); end
            if (m_valid) begin
                compared++;
                if (out_result !== m_res || out_pc !== m_pc || out_op !== m_op || out_store_data !== m_sd || out_dst !== m_dst) begin
                    mismatched++;
                    $display("FAIL rnd_out_data[%0d]: got r=%h pc=%h op=%0d expected r=%h pc=%h op=%0d", c, out_result, out_pc, out_op, m_res, m_pc, m_op);
                end
            end
            compared++; if (redirect_valid !== m_redir) begin mismatched++; $display("FAIL rnd_redirect_valid[%0d]: got %b expected %b", c, redirect_valid, m_redir); end
            if (m_redir) begin
                compared++; if (redirect_pc !== m_rpc) begin mismatched++; $display("FAIL rnd_redirect_pc[%0d]: got %h expected %h", c, redirect_pc, m_rpc); end
            end
            r = $urandom_range(0, 17);
            in_op     = (r < 16) ? op_list[r] : (r == 16) ? OP_NOP : decode_op_t'(5'd29);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = {$urandom, $urandom};
            in_srca   = {$urandom, $urandom};
            in_srcb   = {$urandom, $urandom};
            in_rd1    = {$urandom, $urandom};
            in_rd2    = ($urandom_range(0, 1) != 0) ? in_rd1 : {$urandom, $urandom};
            in_imm    = {$urandom, $urandom};
            in_dst    = 5'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            exp_ready = flush || !m_valid || out_ready;
            compared++; if (in_ready !== exp_ready) begin mismatched++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", c, in_ready, exp_ready); end
            acc = in_valid && exp_ready && !flush;
            ref_ctrl(in_op, in_pc, in_rd1, in_rd2, in_imm, tk, tg);
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1; m_pc = in_pc; m_op = in_op; m_dst = in_dst; m_sd = in_rd2;
                m_res = ref_result(in_op, in_srca, in_srcb);
            end else if (out_ready) m_valid = 1'b0;
            m_redir = acc && tk;
            if (m_redir) m_rpc = tg;
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b0;
        drive(OP_JAL, 64'h700, 64'd1, 64'd1, 64'd0, 64'd0, 64'h10, 5'd5);
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || out_result !== 64'd0)
            begin mismatched++; $display("FAIL async_reset: got v=%b rv=%b r=%h expected 0 0 0", out_valid, redirect_valid, out_result); end
        tick();
        reset = 1'b1; out_ready = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_midop_ready: got %b expected 1", in_ready); end
        tick();
    endtask

`ifdef MUL_EN
    task automatic test_mul();
        int seen;
        out_ready = 1'b1;
        drive(OP_MUL, 64'h800, 64'h1234, 64'h10, 64'd0, 64'h55, 64'd0, 5'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            compared++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin mismatched++; $display("FAIL mul_busy[%0d]: got v=%b rdy=%b expected 0 0", i, out_valid, in_ready); end
            tick();
        end
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mul_early: got %b expected 0", out_valid); end
        tick();
        compared++; if (out_valid !== 1'b1 || out_result !== 64'h12340 || out_op !== OP_MUL || out_pc !== 64'h800)
            begin mismatched++; $display("FAIL mul_result: got v=%b r=%h pc=%h expected v=1 r=12340 pc=800", out_valid, out_result, out_pc); end
        tick();
        // Flush at iteration 10
        drive(OP_MUL, 64'h900, 64'h3, 64'h5, 64'd0, 64'd0, 64'd0, 5'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        compared++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin mismatched++; $display("FAIL mul_flush: got v=%b rdy=%b expected 0 1", out_valid, in_ready); end
        seen = 0;
        for (int i = 0; i < 70; i++) begin if (out_valid === 1'b1) seen++; tick(); end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL mul_flush_no_output: got %0d valid cycles expected 0", seen); end
        // Reset mid-multiply
        drive(OP_MUL, 64'hA00, 64'h7, 64'h9, 64'd0, 64'd0, 64'd0, 5'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL mul_reset_ready: got %b expected 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 70; i++) begin if (out_valid === 1'b1) seen++; tick(); end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL mul_reset_no_output: got %0d valid cycles expected 0", seen); end
    endtask
`endif

    initial begin
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_op = OP_NOP; in_pc = 0; in_srca = 0; in_srcb = 0;
        in_rd1 = 0; in_rd2 = 0; in_imm = 0; in_dst = 0;
        test_reset();
        test_addi_sub();
        test_beq();
        test_jalr();
        test_stall_flush();
        test_unknown();
        test_random();
        test_reset_midop();
`ifdef MUL_EN
        test_mul();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
